uart_rx_word: RTL and testbench



---
 rtl/uart_rx_word.sv | 151 +++++++++++++++
 tb/tb_uart_rx_word.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised rx line, per-byte output,
// and reassembly of NUM_BYTES consecutive good bytes into one word (first byte in the MSBs).
module uart_rx_word #(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter int NUM_BYTES    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    output logic [8*NUM_BYTES-1:0] data_out,
    output logic                   data_valid,
    output logic                   frame_err,
    output logic                   busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int WORD_W = 8 * NUM_BYTES;
    localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_s;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [IDX_W-1:0]   byte_idx;
    logic [7:0]         shift;
    logic [WORD_W-1:0]  word;
    logic [WORD_W-1:0]  word_next;

    // Shift form keeps this valid for any NUM_BYTES, including 1.
    assign word_next = (word << 8) | WORD_W'(shift);

    // NOTE: the synchroniser resets to the idle level so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: non-blocking assignments only, so every branch reads the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            shift      <= '0;
            word       <= '0;
            byte_out   <= '0;
            data_out   <= '0;
            byte_valid <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        // Leave mid-stop-bit so a back-to-back start edge is not missed.
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (rx_s) begin
                            byte_out   <= shift;
                            byte_valid <= 1'b1;
                            word       <= word_next;
                            if (byte_idx == BYTE_LAST) begin
                                data_out   <= word_next;
                                data_valid <= 1'b1;
                                byte_idx   <= '0;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            word      <= '0;
                            byte_idx  <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: a bit-level serial driver plus a queue-based model of which
// bytes, words and framing errors the line traffic should produce.
module tb_uart_rx_word;

    localparam int CLK_FREQ = 307_200;
    localparam int BAUD     = 9600;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int NB       = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    uart_rx_word #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .NUM_BYTES(NB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Observed events, written only by the monitor.
    logic [7:0]  obs_bytes[$];
    logic [31:0] obs_words[$];
    int          obs_ferr      = 0;
    int          obs_incoh     = 0;
    int          obs_rst_pulse = 0;
    logic        rst_q         = 1'b1;

    always @(negedge clk) begin
        if (byte_valid) obs_bytes.push_back(byte_out);
        if (data_valid) begin
            obs_words.push_back(data_out);
            if (!byte_valid || data_out[7:0] !== byte_out) obs_incoh++;
        end
        if (frame_err) obs_ferr++;
        if ((rst || rst_q) && (byte_valid || data_valid || frame_err)) obs_rst_pulse++;
        rst_q = rst;
    end

    // Reference model: what a correct receiver reports for each frame put on the line.
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_words[$];
    logic [7:0]  cur[$];
    int          exp_ferr  = 0;
    logic [7:0]  last_byte = '0;
    logic [31:0] last_word = '0;
    int          ob_mark   = 0;
    int          ow_mark   = 0;
    int          of_mark   = 0;

    task automatic model_frame(input logic [7:0] b, input bit ok);
        logic [31:0] w;
        w = '0;
        if (ok) begin
            exp_bytes.push_back(b);
            last_byte = b;
            cur.push_back(b);
            if (cur.size() == NB) begin
                foreach (cur[i]) w = {w[23:0], cur[i]};
                exp_words.push_back(w);
                last_word = w;
                cur.delete();
            end
        end else begin
            exp_ferr++;
            cur.delete();
        end
    endtask

    task automatic model_reset();
        cur.delete();
        last_byte = '0;
        last_word = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A bad stop bit is followed by one idle bit so the receiver's re-arm sees a high line.
    task automatic send_frame(input logic [7:0] b, input bit ok, input int cpb);
        rx = 1'b0;
        cycles(cpb);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(cpb);
        end
        rx = ok;
        cycles(cpb);
        rx = 1'b1;
        model_frame(b, ok);
        if (!ok) cycles(CPB);
    endtask

    task automatic end_scn(input string name);
        int nb;
        int nw;
        cycles(2 * CPB);
        nb = obs_bytes.size() - ob_mark;
        nw = obs_words.size() - ow_mark;
        check({name, "_nbytes"}, nb, exp_bytes.size());
        for (int i = 0; i < nb && i < exp_bytes.size(); i++)
            check({name, "_byte"}, obs_bytes[ob_mark + i], exp_bytes[i]);
        check({name, "_nwords"}, nw, exp_words.size());
        for (int i = 0; i < nw && i < exp_words.size(); i++)
            check({name, "_word"}, obs_words[ow_mark + i], exp_words[i]);
        check({name, "_nferr"}, obs_ferr - of_mark, exp_ferr);
        check({name, "_byte_out"}, byte_out, last_byte);
        check({name, "_data_out"}, data_out, last_word);
        check({name, "_busy"}, busy, 0);
        ob_mark  = obs_bytes.size();
        ow_mark  = obs_words.size();
        of_mark  = obs_ferr;
        exp_bytes.delete();
        exp_words.delete();
        exp_ferr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  b;
        logic [31:0] w;
        int          cpb;
        int          gap;
        int          nf;
        bit          ok;
        bit          got;

        rst = 1'b1;
        rx  = 1'b1;
        cycles(3);
        check("rst_byte_out", byte_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_pulses", {byte_valid, data_valid, frame_err}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        model_reset();
        cycles(4);

        // Back-to-back word.
        w = 32'h536E6170;
        for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b1, CPB);
        end_scn("word");

        // Short low glitch: false start, back to idle.
        rx = 1'b0;
        cycles(5);
        check("glitch_busy_hi", busy, 1);
        cycles(5);
        rx = 1'b1;
        for (int k = 0; k < CPB && busy; k++) cycles(1);
        check("glitch_busy_lo", busy, 0);
        end_scn("glitch");

        // Bad stop bit clears the partial word.
        send_frame(8'h53, 1'b1, CPB);
        send_frame(8'hA5, 1'b0, CPB);
        w = 32'h01020304;
        for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b1, CPB);
        end_scn("ferr");

        // One-cycle reset during bit 4 of the second byte.
        send_frame(8'h11, 1'b1, CPB);
        b  = 8'h22;
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = b[4];
        cycles(CPB / 2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        rx  = 1'b1;
        model_reset();
        cycles(12 * CPB);
        w = 32'hDEADBEEF;
        for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b1, CPB);
        end_scn("midrst");

        // Transmitter baud error, fast then slow.
        w = 32'h12345678;
        for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b1, CPB - 1);
        end_scn("fast");
        for (int i = 3; i >= 0; i--) send_frame(w[8*i +: 8], 1'b1, CPB + 1);
        end_scn("slow");

        // Break: line low for 30 bit periods, released just after a frame error.
        rx = 1'b0;
        cycles(30 * CPB);
        got = 1'b0;
        for (int k = 0; k < 12 * CPB; k++) begin
            if (frame_err) begin
                got = 1'b1;
                break;
            end
            cycles(1);
        end
        check("brk_ferr_seen", got, 1);
        rx = 1'b1;
        cycles(2 * CPB);
        nf = obs_ferr - of_mark;
        check("brk_ferr_lo", nf >= 3, 1);
        check("brk_ferr_hi", nf <= 5, 1);
        of_mark = obs_ferr;
        cur.delete();
        send_frame(8'h55, 1'b1, CPB);
        end_scn("brk");

        // Random traffic with mild baud error, occasional bad stop bits and idle gaps.
        for (int n = 0; n < 20; n++) begin
            cpb = $urandom_range(CPB + 1, CPB - 1);
            ok  = (cpb == CPB) ? ($urandom_range(5, 0) != 0) : 1'b1;
            b   = 8'($urandom);
            send_frame(b, ok, cpb);
            gap = $urandom_range(2 * CPB, 0);
            if (gap > 0) cycles(gap);
        end
        end_scn("rnd");

        check("no_pulse_near_rst", obs_rst_pulse, 0);
        check("word_with_byte", obs_incoh, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
